conv_job_scheduler: RTL and testbench

- Sits between the host/control path and `pixel_feeder` and sequences the PE-array convolution engine.
- Accepts convolution job descriptors into a small queue and validates each one.
- For each output channel of a job, launches one feeder frame, advancing the kernel base address by one kernel (`kernel_size²` words) per channel.
- Reports per-channel and per-job completion, and supports a graceful abort.

---
 rtl/conv_job_scheduler_pkg.sv | 22 ++
 rtl/conv_job_scheduler_fifo.sv | 71 +++++++
 rtl/conv_job_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_conv_job_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_job_scheduler_pkg.sv
// Shared types and field widths for the convolution job scheduler.
// Descriptors are packed as {img_base, ker_base, img_width, kernel_size, num_ch}.
package conv_job_scheduler_pkg;

    typedef enum logic [2:0] {
        SCHED_IDLE      = 3'd0,
        SCHED_LOAD      = 3'd1,
        SCHED_LAUNCH    = 3'd2,
        SCHED_WAIT_DONE = 3'd3,
        SCHED_ADVANCE   = 3'd4,
        SCHED_DRAIN     = 3'd5
    } sched_state_t;

    localparam int IMG_W_BITS = 5;
    localparam int KSIZE_BITS = 3;
    localparam int KSTEP_BITS = 6;

    function automatic int desc_width(input int addr_w, input int ch_w);
        return 2 * addr_w + IMG_W_BITS + KSIZE_BITS + ch_w;
    endfunction

endpackage

// File: rtl/conv_job_scheduler_fifo.sv
// Synchronous descriptor FIFO with same-cycle push/pop and a flush that
// empties it in one cycle (a push coinciding with a flush is dropped).
module job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/conv_job_scheduler.sv
// Queues convolution job descriptors and launches one pixel_feeder frame per
// output channel, stepping the kernel address by kernel_size^2 each channel.
module conv_job_scheduler
    import conv_job_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int QUEUE_DEPTH = 4,
    parameter int CH_WIDTH    = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [ADDR_WIDTH-1:0]         job_img_base,
    input  logic [ADDR_WIDTH-1:0]         job_ker_base,
    input  logic [IMG_W_BITS-1:0]         job_img_width,
    input  logic [KSIZE_BITS-1:0]         job_kernel_size,
    input  logic [CH_WIDTH-1:0]           job_num_ch,
    output logic                          fd_start,
    output logic                          fd_enable,
    output logic [ADDR_WIDTH-1:0]         fd_img_base_addr,
    output logic [ADDR_WIDTH-1:0]         fd_ker_base_addr,
    output logic [IMG_W_BITS-1:0]         fd_img_width,
    output logic [KSIZE_BITS-1:0]         fd_kernel_size,
    input  logic                          fd_busy,
    input  logic                          fd_frame_done,
    input  logic                          abort,
    output logic                          busy,
    output logic [CH_WIDTH-1:0]           ch_idx,
    output logic                          ch_done,
    output logic                          job_done,
    output logic                          job_err,
    output logic [$clog2(QUEUE_DEPTH):0]  q_count
);

    localparam int DESC_W = desc_width(ADDR_WIDTH, CH_WIDTH);

    sched_state_t r_state;
    sched_state_t w_next_state;

    logic [DESC_W-1:0]     w_fifo_din;
    logic [DESC_W-1:0]     w_fifo_dout;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;

    logic [ADDR_WIDTH-1:0] w_q_img_base;
    logic [ADDR_WIDTH-1:0] w_q_ker_base;
    logic [IMG_W_BITS-1:0] w_q_img_width;
    logic [KSIZE_BITS-1:0] w_q_ksize;
    logic [CH_WIDTH-1:0]   w_q_num_ch;

    logic [ADDR_WIDTH-1:0] r_img_base;
    logic [ADDR_WIDTH-1:0] r_ker_base;
    logic [ADDR_WIDTH-1:0] r_cur_ker;
    logic [IMG_W_BITS-1:0] r_img_width;
    logic [KSIZE_BITS-1:0] r_ksize;
    logic [CH_WIDTH-1:0]   r_num_ch;
    logic [CH_WIDTH-1:0]   r_ch_idx;
    logic                  r_abort_pend;
    logic                  r_ch_done;
    logic                  r_job_done;
    logic                  r_job_err;

    logic                  w_abort_any;
    logic                  w_desc_bad;
    logic [KSTEP_BITS-1:0] w_ker_step;
    logic                  w_start;
    logic                  w_load_ok;
    logic                  w_err;
    logic                  w_ch_fin;
    logic                  w_job_fin;
    logic                  w_advance;

    assign w_fifo_din = {job_img_base, job_ker_base, job_img_width, job_kernel_size, job_num_ch};
    assign {w_q_img_base, w_q_ker_base, w_q_img_width, w_q_ksize, w_q_num_ch} = w_fifo_dout;
    assign w_push     = job_valid && !w_fifo_full;
    assign job_ready  = !w_fifo_full;

    job_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_job_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (q_count)
    );

    // An abort arriving this cycle counts as pending so no launch slips through.
    assign w_abort_any = r_abort_pend || abort;
    assign w_desc_bad  = (r_ksize == '0) || ({2'b00, r_ksize} > r_img_width) || (r_num_ch == '0);
    assign w_ker_step  = {3'b000, r_ksize} * {3'b000, r_ksize};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= SCHED_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_start      = 1'b0;
        w_load_ok    = 1'b0;
        w_err        = 1'b0;
        w_ch_fin     = 1'b0;
        w_job_fin    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            SCHED_IDLE: begin
                if (abort) begin
                    w_flush = 1'b1;
                end else if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = SCHED_LOAD;
                end
            end
            SCHED_LOAD: begin
                if (w_desc_bad) begin
                    w_err        = 1'b1;
                    w_next_state = w_abort_any ? SCHED_DRAIN : SCHED_IDLE;
                end else begin
                    w_load_ok    = 1'b1;
                    w_next_state = SCHED_LAUNCH;
                end
            end
            SCHED_LAUNCH: begin
                if (w_abort_any) begin
                    w_next_state = SCHED_DRAIN;
                end else if (!fd_busy) begin
                    w_start      = 1'b1;
                    w_next_state = SCHED_WAIT_DONE;
                end
            end
            SCHED_WAIT_DONE: begin
                if (fd_frame_done) begin
                    w_ch_fin     = 1'b1;
                    w_next_state = SCHED_ADVANCE;
                end
            end
            SCHED_ADVANCE: begin
                if (w_abort_any) begin
                    w_next_state = SCHED_DRAIN;
                end else if (r_ch_idx == r_num_ch - CH_WIDTH'(1)) begin
                    w_job_fin    = 1'b1;
                    w_next_state = SCHED_IDLE;
                end else begin
                    w_advance    = 1'b1;
                    w_next_state = SCHED_LAUNCH;
                end
            end
            SCHED_DRAIN: begin
                w_flush      = 1'b1;
                w_next_state = SCHED_IDLE;
            end
            default: begin
                w_next_state = SCHED_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_img_base  <= '0;
            r_ker_base  <= '0;
            r_cur_ker   <= '0;
            r_img_width <= '0;
            r_ksize     <= '0;
            r_num_ch    <= '0;
            r_ch_idx    <= '0;
        end else begin
            if (w_pop) begin
                r_img_base  <= w_q_img_base;
                r_ker_base  <= w_q_ker_base;
                r_img_width <= w_q_img_width;
                r_ksize     <= w_q_ksize;
                r_num_ch    <= w_q_num_ch;
            end
            if (w_load_ok) begin
                r_ch_idx  <= '0;
                r_cur_ker <= r_ker_base;
            end
            // Kernel address wraps naturally at 2^ADDR_WIDTH.
            if (w_advance) begin
                r_ch_idx  <= r_ch_idx + CH_WIDTH'(1);
                r_cur_ker <= r_cur_ker + {{(ADDR_WIDTH-KSTEP_BITS){1'b0}}, w_ker_step};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_abort_pend <= 1'b0;
        end else if (r_state == SCHED_DRAIN) begin
            r_abort_pend <= 1'b0;
        end else if (abort && (r_state != SCHED_IDLE)) begin
            r_abort_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ch_done  <= 1'b0;
            r_job_done <= 1'b0;
            r_job_err  <= 1'b0;
        end else begin
            r_ch_done  <= w_ch_fin;
            r_job_done <= w_job_fin;
            r_job_err  <= w_err;
        end
    end

    assign fd_start         = w_start;
    assign fd_enable        = (r_state == SCHED_LOAD) || (r_state == SCHED_LAUNCH) ||
                              (r_state == SCHED_WAIT_DONE) || (r_state == SCHED_ADVANCE);
    assign fd_img_base_addr = r_img_base;
    assign fd_ker_base_addr = r_cur_ker;
    assign fd_img_width     = r_img_width;
    assign fd_kernel_size   = r_ksize;
    assign busy             = (r_state != SCHED_IDLE);
    assign ch_idx           = r_ch_idx;
    assign ch_done          = r_ch_done;
    assign job_done         = r_job_done;
    assign job_err          = r_job_err;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Randomized and directed bench for conv_job_scheduler with a feeder model and
// an event-order scoreboard built from each accepted descriptor.
module tb_conv_job_scheduler;

    localparam int EV_START = 1;
    localparam int EV_CH    = 2;
    localparam int EV_JOB   = 3;
    localparam int EV_ERR   = 4;

    typedef struct {
        int          kind;
        logic [11:0] ker;
        logic [11:0] img;
        logic [4:0]  w;
        logic [2:0]  k;
        int          idx;
    } ev_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [11:0] job_img_base = '0;
    logic [11:0] job_ker_base = '0;
    logic [4:0]  job_img_width = '0;
    logic [2:0]  job_kernel_size = '0;
    logic [3:0]  job_num_ch = '0;
    logic        fd_start;
    logic        fd_enable;
    logic [11:0] fd_img_base_addr;
    logic [11:0] fd_ker_base_addr;
    logic [4:0]  fd_img_width;
    logic [2:0]  fd_kernel_size;
    logic        fd_busy = 1'b0;
    logic        fd_frame_done = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic [3:0]  ch_idx;
    logic        ch_done;
    logic        job_done;
    logic        job_err;
    logic [2:0]  q_count;

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  n_start = 0, n_ch = 0, n_job = 0, n_err = 0;
    int  last_ch_idx = 0, acc_cyc = 0, start_lat = 0;
    logic [11:0] last_ker = '0;
    bit  sb_on = 1'b1;
    bit  mon_start = 1'b0;
    int  fd_lat = 20, fd_hold = 0, fdr_cnt = 0, fdr_drop = 0;
    int  mk, mw, mch, mb;
    ev_t exp_q[$];
    ev_t ev;
    bit  ev_ok;

    conv_job_scheduler #(.ADDR_WIDTH(12), .QUEUE_DEPTH(4), .CH_WIDTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_img_base(job_img_base), .job_ker_base(job_ker_base),
        .job_img_width(job_img_width), .job_kernel_size(job_kernel_size), .job_num_ch(job_num_ch),
        .fd_start(fd_start), .fd_enable(fd_enable),
        .fd_img_base_addr(fd_img_base_addr), .fd_ker_base_addr(fd_ker_base_addr),
        .fd_img_width(fd_img_width), .fd_kernel_size(fd_kernel_size),
        .fd_busy(fd_busy), .fd_frame_done(fd_frame_done),
        .abort(abort), .busy(busy), .ch_idx(ch_idx), .ch_done(ch_done),
        .job_done(job_done), .job_err(job_err), .q_count(q_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e.kind = 0; e.ker = '0; e.img = '0; e.w = '0; e.k = '0; e.idx = 0;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, 0);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    // Feeder: busy the cycle after a start, frame done fd_lat cycles after it,
    // busy released 1+fd_hold cycles after the done pulse.
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            fd_busy = 1'b0; fd_frame_done = 1'b0; fdr_cnt = 0; fdr_drop = 0;
        end else begin
            fd_frame_done = 1'b0;
            if (fdr_drop > 0) begin
                fdr_drop--;
                if (fdr_drop == 0) fd_busy = 1'b0;
            end else if (mon_start) begin
                fd_busy = 1'b1;
                fdr_cnt = fd_lat - 1;
            end else if (fd_busy) begin
                fdr_cnt--;
                if (fdr_cnt == 0) begin
                    fd_frame_done = 1'b1;
                    fdr_drop = 1 + fd_hold;
                end
            end
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        if (!rstn) begin
            mon_start = 1'b0;
        end else begin
            mon_start = fd_start;
            chk("ready_vs_count", job_ready, (q_count != 3'd4));
            if (job_valid && job_ready) begin
                acc_cyc = cyc;
                if (sb_on) begin
                    mk = job_kernel_size; mw = job_img_width; mch = job_num_ch; mb = job_ker_base;
                    if (mk == 0 || mk > mw || mch == 0) begin
                        ev.kind = EV_ERR; ev.idx = 0;
                        exp_q.push_back(ev);
                    end else begin
                        for (int c = 0; c < mch; c++) begin
                            ev.kind = EV_START;
                            ev.ker  = 12'((mb + c * mk * mk) % 4096);
                            ev.img  = job_img_base;
                            ev.w    = job_img_width;
                            ev.k    = job_kernel_size;
                            ev.idx  = c;
                            exp_q.push_back(ev);
                            ev.kind = EV_CH;
                            exp_q.push_back(ev);
                        end
                        ev.kind = EV_JOB;
                        exp_q.push_back(ev);
                    end
                end
            end
            if (fd_start) begin
                n_start++;
                start_lat = cyc - acc_cyc;
                last_ker = fd_ker_base_addr;
                chk("start_while_busy", fd_busy, 1'b0);
                chk("start_enable", fd_enable, 1'b1);
                if (sb_on) begin
                    expect_ev(EV_START, ev, ev_ok);
                    if (ev_ok) begin
                        chk("fd_ker_base_addr", fd_ker_base_addr, ev.ker);
                        chk("fd_img_base_addr", fd_img_base_addr, ev.img);
                        chk("fd_img_width", fd_img_width, ev.w);
                        chk("fd_kernel_size", fd_kernel_size, ev.k);
                    end
                end
            end
            if (ch_done) begin
                n_ch++;
                last_ch_idx = ch_idx;
                if (sb_on) begin
                    expect_ev(EV_CH, ev, ev_ok);
                    if (ev_ok) chk("ch_idx", ch_idx, ev.idx);
                end
            end
            if (job_done) begin
                n_job++;
                if (sb_on) expect_ev(EV_JOB, ev, ev_ok);
            end
            if (job_err) begin
                n_err++;
                if (sb_on) expect_ev(EV_ERR, ev, ev_ok);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_job(input logic [11:0] img, input logic [11:0] ker,
                            input logic [4:0] w, input logic [2:0] k, input logic [3:0] ch);
        int t = 0;
        job_valid = 1'b1; job_img_base = img; job_ker_base = ker;
        job_img_width = w; job_kernel_size = k; job_num_ch = ch;
        @(negedge clk); #1;
        while (!job_ready && t < 500) begin
            step(); @(negedge clk); #1; t++;
        end
        if (t >= 500) chk("push_timeout", 1, 0);
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_starts(input int target);
        int t = 0;
        while (n_start < target && t < 500) begin
            @(negedge clk); #1; t++;
        end
        if (n_start < target) chk("start_timeout", n_start, target);
        step();
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        @(negedge clk); #1;
        while (!(!busy && q_count == 0 && !fd_busy && (!sb_on || exp_q.size() == 0)) && t < budget) begin
            @(negedge clk); #1; t++;
        end
        if (t >= budget) chk("idle_timeout", t, 0);
        step(); step();
    endtask

    task automatic chk_reset_vals();
        chk("rst_job_ready", job_ready, 1'b1);
        chk("rst_fd_start", fd_start, 1'b0);
        chk("rst_fd_enable", fd_enable, 1'b0);
        chk("rst_fd_img", fd_img_base_addr, 12'h000);
        chk("rst_fd_ker", fd_ker_base_addr, 12'h000);
        chk("rst_fd_w_k", {fd_img_width, fd_kernel_size}, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ch_idx", ch_idx, 4'h0);
        chk("rst_pulses", {ch_done, job_done, job_err}, 3'b000);
        chk("rst_q_count", q_count, 3'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, c0, j0, e0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_reset_vals();
        step();
        rstn = 1'b1;
        step();

        // Single job: four channels, kernel step 9
        fd_lat = 20; fd_hold = 0;
        s0 = n_start; c0 = n_ch; j0 = n_job;
        push_job(12'h040, 12'h100, 5'd28, 3'd3, 4'd4);
        wait_starts(s0 + 1);
        chk("start_latency", start_lat, 3);
        wait_idle(400);
        chk("t1_starts", n_start - s0, 4);
        chk("t1_ch_done", n_ch - c0, 4);
        chk("t1_job_done", n_job - j0, 1);
        chk("t1_last_ker", last_ker, 12'h11B);
        chk("t1_last_ch_idx", last_ch_idx, 3);

        // Illegal descriptors
        s0 = n_start; j0 = n_job; e0 = n_err;
        push_job(12'h010, 12'h020, 5'd4, 3'd5, 4'd2);
        push_job(12'h010, 12'h020, 5'd10, 3'd0, 4'd1);
        push_job(12'h010, 12'h020, 5'd10, 3'd3, 4'd0);
        wait_idle(100);
        chk("t2_job_err", n_err - e0, 3);
        chk("t2_starts", n_start - s0, 0);
        chk("t2_job_done", n_job - j0, 0);

        // Queue full while the engine is busy
        push_job(12'h050, 12'h200, 5'd8, 3'd2, 4'd2);
        step(); step();
        for (int i = 0; i < 4; i++) push_job(12'h060, 12'h300 + 12'(i * 16), 5'd6, 3'd2, 4'd1);
        @(negedge clk); #1;
        chk("t3_ready_full", job_ready, 1'b0);
        chk("t3_q_count_full", q_count, 3'd4);
        step();
        push_job(12'h060, 12'h380, 5'd6, 3'd2, 4'd1);
        wait_idle(800);

        // Abort during channel 1 with two jobs queued
        sb_on = 1'b0;
        s0 = n_start; c0 = n_ch; j0 = n_job;
        push_job(12'h070, 12'h400, 5'd9, 3'd3, 4'd4);
        push_job(12'h080, 12'h500, 5'd9, 3'd3, 4'd2);
        push_job(12'h090, 12'h600, 5'd9, 3'd3, 4'd2);
        wait_starts(s0 + 2);
        step(); step();
        @(negedge clk); #1;
        chk("t4_q_before_abort", q_count, 3'd2);
        step();
        s0 = n_start; c0 = n_ch;
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_idle(200);
        chk("t4_starts_after", n_start - s0, 0);
        chk("t4_ch_done_after", n_ch - c0, 1);
        chk("t4_ch_idx", last_ch_idx, 1);
        chk("t4_job_done", n_job - j0, 0);
        chk("t4_q_count", q_count, 3'd0);
        chk("t4_busy", busy, 1'b0);
        exp_q.delete();
        sb_on = 1'b1;

        // Kernel address wrap
        fd_lat = 5;
        push_job(12'h0A0, 12'hFFC, 5'd12, 3'd3, 4'd2);
        wait_idle(100);
        chk("t5_wrap_addr", last_ker, 12'h005);

        // Asynchronous reset while waiting on a frame, with a job queued
        fd_lat = 20;
        s0 = n_start;
        push_job(12'h0B0, 12'h700, 5'd10, 3'd3, 4'd3);
        push_job(12'h0C0, 12'h710, 5'd10, 3'd3, 4'd1);
        wait_starts(s0 + 1);
        step(); step();
        #2;
        sb_on = 1'b0;
        rstn = 1'b0;
        #1;
        chk_reset_vals();
        exp_q.delete();
        step(); step();
        rstn = 1'b1;
        sb_on = 1'b1;
        step();
        j0 = n_job; fd_lat = 6;
        push_job(12'h0D0, 12'h720, 5'd16, 3'd4, 4'd2);
        wait_idle(200);
        chk("t6_job_after_reset", n_job - j0, 1);

        // Randomized descriptors against the scoreboard
        for (int j = 0; j < 30; j++) begin
            fd_lat = $urandom_range(2, 6);
            fd_hold = $urandom_range(0, 2);
            push_job(12'($urandom), 12'($urandom), 5'($urandom_range(0, 12)),
                     3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle(3000);
        chk("sb_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
